// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - datapath/control bundle for the multicycle controller
// The datapath side (master) presents opcode and flags; the controller (slave) drives strobes.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       IRWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemToReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       PCSource;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    output opcode, zero, mem_ready,
    input  PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegWrite,
           ALUSrcA, PCSource, ALUSrcB, ALUOp, instr_done, illegal, state
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output PCWrite, IRWrite, IorD, MemRead, MemWrite, MemToReg, RegWrite,
           ALUSrcA, PCSource, ALUSrcB, ALUOp, instr_done, illegal, state
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with memory-ready stalls
// Optional I-type ALU path (opcode 0010011) enabled by macro IMM_ALU_EN.
module multicycle_control (
  input logic                    clk,
  input logic                    reset,
  multicycle_control_if.slave    bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    ALU_WB   = 4'd7,
    BRANCH   = 4'd8,
    I_EXEC   = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef IMM_ALU_EN
  localparam logic [6:0] OP_IMM    = 7'b0010011;
`endif

  state_t state_q, state_d;

  logic       pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_write;
  logic       alu_src_a, pc_source, instr_done, illegal;
  logic [1:0] alu_src_b, alu_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    pc_source  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = bus.mem_ready;
        pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is dispatched
        alu_src_b = 2'b10;
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = MEM_ADDR;
          OP_RTYPE:          state_d = R_EXEC;
          OP_BRANCH:         state_d = BRANCH;
`ifdef IMM_ALU_EN
          OP_IMM:            state_d = I_EXEC;
`endif
          default: begin
            state_d    = FETCH;
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (bus.opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) begin
          instr_done = 1'b1;
          state_d    = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ALU_WB;
      end
      ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_source  = 1'b1;
        pc_write   = bus.zero;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
`ifdef IMM_ALU_EN
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALU_WB;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  // Outputs are gated by reset so nothing strobes while it is held low
  assign bus.PCWrite    = reset & pc_write;
  assign bus.IRWrite    = reset & ir_write;
  assign bus.IorD       = reset & iord;
  assign bus.MemRead    = reset & mem_read;
  assign bus.MemWrite   = reset & mem_write;
  assign bus.MemToReg   = reset & mem_to_reg;
  assign bus.RegWrite   = reset & reg_write;
  assign bus.ALUSrcA    = reset & alu_src_a;
  assign bus.PCSource   = reset & pc_source;
  assign bus.ALUSrcB    = reset ? alu_src_b : 2'b00;
  assign bus.ALUOp      = reset ? alu_op : 2'b00;
  assign bus.instr_done = reset & instr_done;
  assign bus.illegal    = reset & illegal;
  assign bus.state      = reset ? state_q : 4'd0;

endmodule
